prescaled_counter: RTL and testbench



---
 rtl/prescaled_counter_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 39 +++
 rtl/prescaled_counter.sv | 148 ++++++++++++++
 tb/tb_prescaled_counter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/prescaled_counter_pkg.sv
// Shared constants, step-source encoding and counter-width helpers for prescaled_counter.
package prescaled_counter_pkg;

  localparam int CLK50M_HZ    = 50_000_000;
  localparam int DEF_PRESCALE = CLK50M_HZ / 2;

  typedef enum logic {
    SRC_TICK = 1'b0,
    SRC_STEP = 1'b1
  } step_src_e;

  function automatic int presc_cnt_w(input int prescale);
    return ($clog2(prescale) < 1) ? 1 : $clog2(prescale);
  endfunction

  function automatic int db_cnt_w(input int cycles);
    return ($clog2(cycles + 1) < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle TICK every PRESCALE cycles of CLK50M.
module tick_prescaler
  import prescaled_counter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic CLK50M,
  input  logic reset,
  output logic TICK
);

  localparam int            CW   = presc_cnt_w(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next divider count, wrapping at PRESCALE-1
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider register
  always_ff @(posedge CLK50M) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/prescaled_counter.sv
// Modulo up/down counter with load/clear, ENP/ENT cascade enables and a prescaler or STEP source.
// Build option: define PRESCALED_COUNTER_DEBOUNCE_EN to insert the STEP debounce filter.
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int MODULUS         = 10,
  parameter int PRESCALE        = DEF_PRESCALE,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic             CLK50M,
  input  logic             reset,
  input  logic             STEP,
  input  logic             SRC_SEL,
  input  logic             UP,
  input  logic             LDb,
  input  logic             CLRb,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             isHalf,
  output logic             TICK
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] HALF_Q = WIDTH'(MODULUS / 2);

  logic             tick_s;
  logic             sync1_q;
  logic             sync2_q;
  logic             filt_s;
  logic             prev_q;
  logic             edge_s;
  logic             step_s;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .CLK50M(CLK50M),
    .reset (reset),
    .TICK  (tick_s)
  );

  // Two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge CLK50M) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= STEP;
      sync2_q <= sync1_q;
    end
  end

`ifdef PRESCALED_COUNTER_DEBOUNCE_EN
  localparam int            DW      = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt_q;
  logic [DW-1:0] db_cnt_d;
  logic          filt_q;
  logic          filt_d;

  // Filtered level only follows a new level held for DEBOUNCE_CYCLES cycles
  always_comb begin
    db_cnt_d = '0;
    filt_d   = filt_q;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DB_LAST) begin
        filt_d   = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Debounce state
  always_ff @(posedge CLK50M) begin
    if (reset) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  assign filt_s = filt_q;
`else
  // DEBOUNCE_CYCLES has no role without the filter
  logic unused_db_s;
  assign unused_db_s = (DEBOUNCE_CYCLES > 0);
  assign filt_s      = sync2_q;
`endif

  // Edge-detector history
  always_ff @(posedge CLK50M) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= filt_s;
    end
  end

  // Edges seen while the tick source is selected are simply dropped
  assign edge_s = filt_s & ~prev_q;
  assign step_s = (step_src_e'(SRC_SEL) == SRC_STEP) ? edge_s : tick_s;

  // Counter next state: clear, then clamped load, then enabled step
  always_comb begin
    q_d = q_q;
    if (!CLRb) begin
      q_d = '0;
    end else if (!LDb) begin
      q_d = (D > MAX_Q) ? MAX_Q : D;
    end else if (ENP && ENT && step_s) begin
      if (UP) begin
        q_d = (q_q == MAX_Q) ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = (q_q == '0) ? MAX_Q : q_q - WIDTH'(1);
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count register
  always_ff @(posedge CLK50M) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q      = q_q;
  assign RCO    = ENT & (UP ? (q_q == MAX_Q) : (q_q == '0));
  assign isHalf = (q_q >= HALF_Q);
  assign TICK   = tick_s;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter with a reference model feeding an expected-value queue.
module tb_prescaled_counter;

  localparam int PRE = 4;
`ifdef PRESCALED_COUNTER_DEBOUNCE_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst, step, src, up, ldb, clrb, enp, ent;
  logic [3:0] d;
  logic [3:0] q, q0, q1;
  logic       rco, half, tick, rco0, half0, tick0, rco1, half1, tick1;

  always #5 clk = ~clk;

  prescaled_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(PRE), .DEBOUNCE_CYCLES(8)) u_dut (
    .CLK50M(clk), .reset(rst), .STEP(step), .SRC_SEL(src), .UP(up), .LDb(ldb), .CLRb(clrb),
    .ENP(enp), .ENT(ent), .D(d), .Q(q), .RCO(rco), .isHalf(half), .TICK(tick));

  prescaled_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(PRE), .DEBOUNCE_CYCLES(8)) u_c0 (
    .CLK50M(clk), .reset(rst), .STEP(1'b0), .SRC_SEL(1'b0), .UP(1'b1), .LDb(1'b1), .CLRb(1'b1),
    .ENP(1'b1), .ENT(1'b1), .D(4'd0), .Q(q0), .RCO(rco0), .isHalf(half0), .TICK(tick0));

  prescaled_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(PRE), .DEBOUNCE_CYCLES(8)) u_c1 (
    .CLK50M(clk), .reset(rst), .STEP(1'b0), .SRC_SEL(1'b0), .UP(1'b1), .LDb(1'b1), .CLRb(1'b1),
    .ENP(1'b1), .ENT(rco0), .D(4'd0), .Q(q1), .RCO(rco1), .isHalf(half1), .TICK(tick1));

  typedef struct {
    int   q;
    logic tick;
    int   c0;
    int   c1;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    m_pre = 0, m_q = 0, m_casc = 0;
  logic  m_edge = 1'b0;
  logic  track = 1'b0;
  logic [15:0] seen_c1 = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model, queue the expectation, then compare after the edge
  task automatic cyc();
    exp_t e;
    logic tk, stp;
    tk  = (m_pre == PRE - 1);
    stp = src ? m_edge : tk;
    if (rst) begin
      m_pre = 0; m_q = 0; m_casc = 0;
    end else begin
      m_pre = tk ? 0 : m_pre + 1;
      if (tk) m_casc = (m_casc + 1) % 100;
      if (!clrb) m_q = 0;
      else if (!ldb) m_q = (d > 4'd9) ? 9 : int'(d);
      else if (enp && ent && stp) begin
        if (up) m_q = (m_q == 9) ? 0 : m_q + 1;
        else    m_q = (m_q == 0) ? 9 : m_q - 1;
      end
    end
    e.q = m_q; e.tick = (m_pre == PRE - 1); e.c0 = m_casc % 10; e.c1 = m_casc / 10;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("Q", q, e.q);
    chk("TICK", tick, e.tick);
    chk("RCO", rco, ent && (up ? (e.q == 9) : (e.q == 0)));
    chk("isHalf", half, e.q >= 5);
    chk("C0_Q", q0, e.c0);
    chk("C0_TICK", tick0, e.tick);
    chk("C0_isHalf", half0, e.c0 >= 5);
    chk("C1_Q", q1, e.c1);
    if (track) seen_c1[q1] = 1'b1;
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; src = 1'b0; up = 1'b0; ldb = 1'b1; clrb = 1'b1;
    enp = 1'b1; ent = 1'b1; d = 4'd0;
    // reset state (UP=0 so RCO follows ENT & !UP)
    repeat (2) cyc();
    rst = 1'b0; up = 1'b1;
    // free count 0..9 then back to 0
    repeat (40) cyc();
    chk("free_wrap", q, 0);

    // load clamp then count down with wrap
    ldb = 1'b0; d = 4'd12; cyc();
    chk("load_clamp", q, 9);
    ldb = 1'b1; up = 1'b0;
    repeat (40) cyc();
    chk("down_wrap", q, 9);

    // priority: clear over load on a tick cycle, then load, then reset over load
    for (int i = 0; i < 8 && m_pre != PRE - 1; i++) cyc();
    chk("tick_align", tick, 1);
    clrb = 1'b0; ldb = 1'b0; d = 4'd3; cyc();
    chk("clr_over_ld", q, 0);
    clrb = 1'b1; cyc();
    chk("load_3", q, 3);
    rst = 1'b1; cyc();
    chk("rst_over_ld", q, 0);
    rst = 1'b0; ldb = 1'b1;

    // enables
    ldb = 1'b0; d = 4'd9; cyc();
    ldb = 1'b1; up = 1'b1; enp = 1'b0;
    repeat (8) cyc();
    chk("enp_hold_rco", rco, 1);
    ent = 1'b0;
    repeat (8) cyc();
    chk("ent_hold_q", q, 9);
    enp = 1'b1; ent = 1'b1;

    // STEP source: one increment LAT edges after the rising edge
    src = 1'b1; ldb = 1'b0; d = 4'd2; cyc();
    ldb = 1'b1; step = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      m_edge = (k == LAT);
      cyc();
    end
    m_edge = 1'b0; step = 1'b0;
    repeat (15) cyc();
    chk("step_once", q, 3);
`ifdef PRESCALED_COUNTER_DEBOUNCE_EN
    step = 1'b1; repeat (5) cyc();
    step = 1'b0; repeat (20) cyc();
    chk("glitch_ignored", q, 3);
`endif
    // STEP edge while tick source selected is discarded
    src = 1'b0; enp = 1'b0; step = 1'b1;
    repeat (20) cyc();
    src = 1'b1; enp = 1'b1;
    repeat (10) cyc();
    chk("edge_discarded", q, 3);
    step = 1'b0; src = 1'b0;
    repeat (15) cyc();

    // cascade: 100 ticks from reset brings both stages back to 0
    rst = 1'b1; cyc();
    rst = 1'b0; seen_c1 = 16'h0000; track = 1'b1;
    repeat (400) cyc();
    track = 1'b0;
    chk("casc_c0", q0, 0);
    chk("casc_c1", q1, 0);
    chk("casc_c1_seen", seen_c1, 16'h03FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
